// File: rtl/div_iter_if.sv
// Divide handshake between the ALU (master) and the iterative divider (slave).
// Carries operands, the opn_valid/res_ready/res_valid handshake, the result and busy.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sign;
    logic               opn_valid;
    logic               res_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] result;
    logic               busy;

    modport master (
        output a, b, sign, opn_valid, res_ready,
        input  res_valid, result, busy
    );

    modport slave (
        input  a, b, sign, opn_valid, res_ready,
        output res_valid, result, busy
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, responder side of the ALU divide handshake.
// Result is {remainder, quotient}; signed ops divide magnitudes and fix up signs on completion.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    div_iter_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH:0]     rem_q,       rem_d;
    logic [WIDTH-1:0]   quo_q,       quo_d;
    logic [WIDTH-1:0]   div_q,       div_d;
    logic               sign_quo_q,  sign_quo_d;
    logic               sign_rem_q,  sign_rem_d;
    logic               div_zero_q,  div_zero_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] result_q,    result_d;

    logic [WIDTH+1:0]   rem_shift;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               neg_a;
    logic               neg_b;

    always_comb begin
        // Dividend shifts out of quo_q into the partial remainder one bit per iteration.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {2'b00, div_q};
        rem_next  = trial[WIDTH+1] ? rem_shift[WIDTH:0] : trial[WIDTH:0];
        quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        quo_fix   = div_zero_q ? '1 : (sign_quo_q ? -quo_next : quo_next);
        rem_fix   = sign_rem_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

        neg_a = bus.sign & bus.a[WIDTH-1];
        neg_b = bus.sign & bus.b[WIDTH-1];

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.opn_valid) begin
                        state_d    = S_BUSY;
                        cnt_d      = '0;
                        rem_d      = '0;
                        quo_d      = neg_a ? -bus.a : bus.a;
                        div_d      = neg_b ? -bus.b : bus.b;
                        sign_quo_d = neg_a ^ neg_b;
                        sign_rem_d = neg_a;
                        div_zero_d = (bus.b == '0);
                    end
                end
                S_BUSY: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = S_DONE;
                        result_d = {rem_fix, quo_fix};
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            div_zero_q  <= div_zero_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: the driver queues hand-computed results, and a
// monitor pops them whenever res_valid rises, also checking latency and result hold.
module tb_div_iter;

    typedef struct {
        logic [63:0] res;
        int          start;
    } exp_t;

    logic clk;
    logic resetn;
    logic flush;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: got busy=%b expected busy=0", bus.busy);
        end
    endtask

    // Presents one op; returns at the negedge of the first BUSY cycle.
    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic isgn,
                                 input logic [63:0] exp, input bit track);
        waitIdle();
        bus.a         = ia;
        bus.b         = ib;
        bus.sign      = isgn;
        bus.opn_valid = 1'b1;
        if (track) sb.push_back('{exp, cyc});
        @(negedge clk);
        bus.opn_valid = 1'b0;
        bus.a         = ~ia;
        bus.b         = ib ^ 32'h5A5A_0001;
        bus.sign      = ~isgn;
        checkOutput("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    endtask

    // Monitor: pops the scoreboard on each rising res_valid, checks hold while stalled
    // and that the cycle after a handshake is idle.
    initial begin
        bit          prev_valid = 1'b0;
        bit          hs_prev    = 1'b0;
        logic [63:0] held       = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                prev_valid = 1'b0;
                hs_prev    = 1'b0;
                continue;
            end
            if (hs_prev) begin
                checkOutput("idle_after_hs_busy",  {63'd0, bus.busy},      64'd0);
                checkOutput("idle_after_hs_valid", {63'd0, bus.res_valid}, 64'd0);
            end
            if (bus.res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_valid: got res_valid=1 result=%h expected no result", bus.result);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result",  bus.result,        e.res);
                    checkOutput("latency", 64'(cyc - e.start), 64'd33);
                end
                held = bus.result;
            end else if (bus.res_valid && prev_valid) begin
                checkOutput("hold_result", bus.result, held);
            end
            hs_prev    = bus.res_valid && bus.res_ready;
            prev_valid = bus.res_valid;
        end
    end

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        resetn        = 1'b0;
        flush         = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b0;
        bus.res_ready = 1'b1;

        @(negedge clk);
        checkOutput("reset_busy",   {63'd0, bus.busy},      64'd0);
        checkOutput("reset_valid",  {63'd0, bus.res_valid}, 64'd0);
        checkOutput("reset_result", bus.result,             64'd0);
        @(negedge clk);
        resetn = 1'b1;

        $display("[TB] directed divides");
        applyStimulus(32'd100,       32'd7,         1'b0, 64'h0000_0002_0000_000E, 1'b1);
        applyStimulus(32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        applyStimulus(32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b1);
        applyStimulus(32'h0000_1234, 32'd0,         1'b1, 64'h0000_1234_FFFF_FFFF, 1'b1);
        applyStimulus(32'h0000_1234, 32'd0,         1'b0, 64'h0000_1234_FFFF_FFFF, 1'b1);
        applyStimulus(32'hFFFF_FFFB, 32'd0,         1'b1, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1);
        applyStimulus(32'hFFFF_FFF9, 32'd2,         1'b0, 64'h0000_0001_7FFF_FFFC, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h10,        1'b0, 64'h0000_000F_0FFF_FFFF, 1'b1);
        applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFE_0000_000E, 1'b1);

        $display("[TB] result hold and back-to-back");
        waitIdle();
        bus.res_ready = 1'b0;
        applyStimulus(32'd1000, 32'd10, 1'b0, 64'h0000_0000_0000_0064, 1'b1);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checkOutput("stall_valid_6th", {63'd0, bus.res_valid}, 64'd1);
        bus.res_ready = 1'b1;
        bus.opn_valid = 1'b1;
        bus.a         = 32'h55;
        bus.b         = 32'd5;
        bus.sign      = 1'b0;
        sb.push_back('{64'h0000_0000_0000_0011, cyc + 1});
        @(negedge clk);
        checkOutput("b2b_idle_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.opn_valid = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        checkOutput("b2b_accepted", {63'd0, bus.busy}, 64'd1);

        $display("[TB] flush mid-operation");
        applyStimulus(32'd100, 32'd7, 1'b0, 64'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy",  {63'd0, bus.busy},      64'd0);
        checkOutput("flush_valid", {63'd0, bus.res_valid}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("flush_no_late_valid", {63'd0, bus.res_valid}, 64'd0);
        applyStimulus(32'd10, 32'd3, 1'b0, 64'h0000_0001_0000_0003, 1'b1);

        $display("[TB] async reset mid-operation");
        applyStimulus(32'd123456, 32'd7, 1'b0, 64'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_busy",   {63'd0, bus.busy},      64'd0);
        checkOutput("async_reset_valid",  {63'd0, bus.res_valid}, 64'd0);
        checkOutput("async_reset_result", bus.result,             64'd0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(32'd50, 32'd6, 1'b0, 64'h0000_0002_0000_0008, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks += sb.size();
            errors += sb.size();
            $display("[TB] FAIL drain: got %0d results outstanding expected 0", sb.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle radix-2 restoring divider for the execute stage; it is the responder side of the ALU's divide handshake. The ALU raises `opn_valid` for DIV/DIVU. It holds the instruction in E until `res_valid`, then accepts the 64-bit `{remainder, quotient}` result through `res_ready`. That result is written into HI/LO.

## Interface
- `WIDTH`, 32: operand width; result is `2*WIDTH`.
- `clk`  in  1: rising-edge clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort; it is the E-stage flush.
- `a`  in  WIDTH: dividend.
- `b`  in  WIDTH: divisor.
- `sign`  in  1: 1 = signed (DIV), 0 = unsigned (DIVU).
- `opn_valid`  in  1: the master has operands ready.
- `res_ready`  in  1: the master can take the result this cycle.
- `res_valid`  out  1: the result is valid.
- `result`  out  2*WIDTH: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`.
- `busy`  out  1: high in BUSY and DONE.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - When `opn_valid=1` and `flush=0`, capture the operands:
    - `sign_q` = `sign & (a[31]^b[31])`.
    - `sign_r` = `sign & a[31]`.
    - Dividend magnitude: `|a|` if signed, else `a`.
    - Divisor magnitude: `|b|` if signed, else `b`.
  - Clear the partial remainder (WIDTH+1 bits) and set the counter to 0. Go to BUSY.
  - `a` and `b` are sampled only in this cycle; later changes are ignored.
- **BUSY**, one iteration per cycle:
  - Shift `{rem, quo}` left by 1 and trial-subtract the divisor from `rem`.
  - If the trial is non-negative, keep the difference and set quotient bit = 1. Otherwise restore and set the bit to 0.
  - After WIDTH iterations (counter = WIDTH-1 on the last one), go to DONE.
- **DONE**
  - The final quotient is negated if `sign_q`; the remainder is negated if `sign_r`. Both are registered into `result`.
  - `res_valid=1`. On `res_valid & res_ready`, go to IDLE.
  - `result` holds its value after the handshake until the next completion.
- **Divide by zero:** no trap. For both signed and unsigned, quotient = `32'hFFFF_FFFF` and remainder = `a`. This is forced explicitly, not left to the sign fix-up.
- **Signed overflow:** `0x8000_0000 / 0xFFFF_FFFF` gives quotient `0x8000_0000` and remainder 0.
- **`flush`:** in any state, the next state is IDLE and `res_valid` goes 0 next cycle. An op is never accepted in a flush cycle.
- **`resetn`:** low at any time, including mid-operation, puts the block in IDLE.
- **Priority:** `resetn` > `flush` > handshake/iteration.

## Timing
- **Reset values:** `res_valid=0`, `busy=0`, `result=0`, state IDLE, counter 0.
- **Latency:**
  - Accept edge at cycle 0.
  - BUSY during cycles 1..32.
  - `res_valid=1` from cycle 33.
  - Minimum occupancy is 34 cycles, including the handshake cycle.
- **Stall behaviour:**
  - `res_valid` stays high and `result` stays stable while `res_ready=0`, for unbounded cycles.
  - `res_valid` falls the cycle after the handshake.
- **Back-to-back:**
  - The cycle after the handshake is IDLE.
  - If `opn_valid` is still 1 there, a new op is accepted, because the master has advanced.
  - There is no same-cycle accept in DONE.
- **Master stall signal:** the master derives its stall as `opn_valid & ~res_valid`. `res_valid` is a registered output with no combinational path from the inputs.
- **Ignored inputs:** `opn_valid` is ignored in BUSY and DONE. `res_ready` is ignored outside DONE.

## Test plan
- **Basic unsigned divide:**
  - Stimulus: unsigned `a=100`, `b=7`, `res_ready=1`.
  - Required: `res_valid` at cycle 33, `result=64'h0000_0002_0000_000E`, IDLE at cycle 34.
- **Signed divide:**
  - Stimulus: signed `a=-7` (`FFFF_FFF9`), `b=2`.
  - Required: `result=64'hFFFF_FFFF_FFFF_FFFD`.
  - Also signed `a=7`, `b=-2`, with required `result=64'h0000_0001_FFFF_FFFD`.
- **Corner cases:**
  - Signed `0x8000_0000 / -1` must give `64'h0000_0000_8000_0000`.
  - `a=0x1234`, `b=0`, both signed and unsigned, must give `64'h0000_1234_FFFF_FFFF`.
- **Result hold and back-to-back:**
  - Stimulus: hold `res_ready=0` for 5 cycles after `res_valid`.
  - Required: `res_valid` and `result` are stable, with the handshake on the 6th cycle.
  - Then keep `opn_valid=1` with new operands: acceptance must occur the cycle after the handshake.
- **Flush mid-operation:**
  - Stimulus: pulse `flush` at cycle 10 of BUSY.
  - Required: IDLE, `busy=0` and `res_valid=0` next cycle, and no spurious `res_valid` later.
  - A new op 10/3 issued next must return `64'h0000_0001_0000_0003` 33 cycles after its accept.
- **Asynchronous reset mid-operation:**
  - Stimulus: assert `resetn=0` asynchronously mid-BUSY.
  - Required: outputs go to reset values immediately, without waiting for a clock edge. After release, a new op completes correctly.
